// File: rtl/usb_frame_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : usb_frame_pkg                                                  |
// | Purpose : Shared definitions for the endpoint-2 response framer and the  |
// |           downstream command parser: default start-of-frame bytes,       |
// |           header length and the framer state encoding.                   |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package usb_frame_pkg;

  // Default start-of-frame marker bytes.
  localparam logic [7:0] SOF0_DEFAULT = 8'hAA;
  localparam logic [7:0] SOF1_DEFAULT = 8'h55;

  // SOF0, SOF1, CMD, LEN_H, LEN_L.
  localparam int FRAME_HDR_LEN = 5;

  // Framer state: each state names the next byte to be emitted. SOF0 has no
  // state of its own because it is emitted in the same cycle the start is
  // accepted.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOF1    = 3'd1,
    ST_CMD     = 3'd2,
    ST_LEN_H   = 3'd3,
    ST_LEN_L   = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_CSUM    = 3'd6
  } frame_state_e;

  // Total number of bytes on the wire for a payload of the given length.
  function automatic int frame_total_len(input logic [15:0] len);
    return FRAME_HDR_LEN + int'(len) + 1;
  endfunction

endpackage : usb_frame_pkg
`default_nettype wire

// File: rtl/usb_upload_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : usb_upload_framer                                              |
// | Purpose : Builds SOF0 SOF1 CMD LEN_H LEN_L <payload> CSUM frames and     |
// |           paces them onto the CDC upload byte port (no backpressure).    |
// |           Payload is pulled through a valid/ready handshake; a starved   |
// |           payload is padded with 0x00 after STALL_TIMEOUT cycles.        |
// | Ports   : i_clk, i_rst_n (sync, active-low)                              |
// |           i_start, i_cmd[7:0], i_len[15:0]      frame request            |
// |           i_pl_data[7:0], i_pl_valid, o_pl_ready payload source         |
// |           o_usb_upload_data[7:0], o_usb_upload_valid  byte stream        |
// |           o_busy, o_done, o_err                   status                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module usb_upload_framer
  import usb_frame_pkg::*;
#(
  parameter int         BYTE_GAP      = 0,
  parameter int         STALL_TIMEOUT = 1024,
  parameter logic [7:0] SOF0          = SOF0_DEFAULT,
  parameter logic [7:0] SOF1          = SOF1_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_cmd,
  input  logic [15:0] i_len,
  input  logic [7:0]  i_pl_data,
  input  logic        i_pl_valid,
  output logic        o_pl_ready,
  output logic [7:0]  o_usb_upload_data,
  output logic        o_usb_upload_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int GW = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;
  localparam int SW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] C_GAP_LOAD = GW'(BYTE_GAP);

  frame_state_e  state_q, state_d;
  logic [GW-1:0] gap_q,   gap_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [15:0]   rem_q,   rem_d;
  logic [15:0]   len_q,   len_d;
  logic [7:0]    cmd_q,   cmd_d;
  logic [7:0]    csum_q,  csum_d;
  logic          pad_q,   pad_d;
  logic          fin_q,   fin_d;    // CSUM already emitted, waiting out the gap
  logic [7:0]    data_q,  data_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic          err_q,   err_d;

  logic          w_emit;
  logic [7:0]    w_emit_byte;

  always_comb begin
    state_d     = state_q;
    gap_d       = (gap_q == '0) ? '0 : gap_q - GW'(1);
    stall_d     = stall_q;
    rem_d       = rem_q;
    len_d       = len_q;
    cmd_d       = cmd_q;
    csum_d      = csum_q;
    pad_d       = pad_q;
    fin_d       = fin_q;
    err_d       = err_q;
    done_d      = 1'b0;
    w_emit      = 1'b0;
    w_emit_byte = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          cmd_d       = i_cmd;
          len_d       = i_len;
          rem_d       = i_len;
          csum_d      = 8'h00;
          stall_d     = '0;
          pad_d       = 1'b0;
          fin_d       = 1'b0;
          err_d       = 1'b0;
          w_emit      = 1'b1;
          w_emit_byte = SOF0;
          state_d     = ST_SOF1;
        end
      end
      ST_SOF1: begin
        if (gap_q == '0) begin
          w_emit      = 1'b1;
          w_emit_byte = SOF1;
          state_d     = ST_CMD;
        end
      end
      ST_CMD: begin
        if (gap_q == '0) begin
          w_emit      = 1'b1;
          w_emit_byte = cmd_q;
          csum_d      = csum_q + cmd_q;
          state_d     = ST_LEN_H;
        end
      end
      ST_LEN_H: begin
        if (gap_q == '0) begin
          w_emit      = 1'b1;
          w_emit_byte = len_q[15:8];
          csum_d      = csum_q + len_q[15:8];
          state_d     = ST_LEN_L;
        end
      end
      ST_LEN_L: begin
        if (gap_q == '0) begin
          w_emit      = 1'b1;
          w_emit_byte = len_q[7:0];
          csum_d      = csum_q + len_q[7:0];
          state_d     = (len_q == 16'd0) ? ST_CSUM : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (gap_q == '0) begin
          if (pad_q) begin
            // Padding: a zero byte goes out on every gap-zero cycle.
            w_emit      = 1'b1;
            w_emit_byte = 8'h00;
            rem_d       = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = ST_CSUM;
          end else if (ready_q && i_pl_valid) begin
            w_emit      = 1'b1;
            w_emit_byte = i_pl_data;
            csum_d      = csum_q + i_pl_data;
            rem_d       = rem_q - 16'd1;
            stall_d     = '0;
            if (rem_q == 16'd1) state_d = ST_CSUM;
          end else if (ready_q && (STALL_TIMEOUT != 0)) begin
            stall_d = stall_q + SW'(1);
            if ((int'(stall_q) + 1) >= STALL_TIMEOUT) begin
              pad_d = 1'b1;
              err_d = 1'b1;
            end
          end
        end
      end
      ST_CSUM: begin
        if (gap_q == '0) begin
          if (!fin_q) begin
            w_emit      = 1'b1;
            w_emit_byte = csum_q;
            done_d      = 1'b1;
            fin_d       = 1'b1;
          end else begin
            // Gap after the checksum has elapsed; frame is over.
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    data_d  = w_emit ? w_emit_byte : data_q;
    valid_d = w_emit;
    if (w_emit) gap_d = C_GAP_LOAD;

    // Registered handshake/status derived from the next-cycle state.
    ready_d = (state_d == ST_PAYLOAD) && (gap_d == '0) && !pad_d;
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      stall_q <= '0;
      rem_q   <= 16'd0;
      len_q   <= 16'd0;
      cmd_q   <= 8'h00;
      csum_q  <= 8'h00;
      pad_q   <= 1'b0;
      fin_q   <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      stall_q <= stall_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
      csum_q  <= csum_d;
      pad_q   <= pad_d;
      fin_q   <= fin_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_pl_ready         = ready_q;
  assign o_usb_upload_data  = data_q;
  assign o_usb_upload_valid = valid_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_err              = err_q;

endmodule : usb_upload_framer
`default_nettype wire
